// File: rtl/udp_tx_payload_buf_pkg.sv
// Shared definitions for the UDP TX payload path: buffer/queue sizing defaults
// and the TX-side handshake state encoding.
package udp_tx_payload_buf_pkg;

  localparam int unsigned UDP_DEPTH_LOG2     = 11;
  localparam int unsigned UDP_LEN_DEPTH_LOG2 = 3;
  localparam int unsigned UDP_MAX_LEN        = 1472;
  localparam int unsigned UDP_TIMEOUT_CYC    = 1024;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/udp_tx_payload_buf_len_fifo.sv
// Committed-frame length queue: synchronous FIFO whose head is held in an
// output register so it is readable in the same cycle it is popped.
module udp_len_fifo
  import udp_tx_payload_buf_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = UDP_LEN_DEPTH_LOG2
) (
  input  logic          clk_125m,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = AW + 1;

  logic [DW-1:0] mem [2**AW];
  logic [PW-1:0] wp, rp, cnt;
  logic [AW-1:0] rp_nxt;
  logic          do_wr, do_rd;

  assign full   = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign empty  = (wp == rp);
  assign cnt    = wp - rp;
  assign rp_nxt = rp[AW-1:0] + AW'(1);
  assign do_wr  = wr_en && !full;
  assign do_rd  = rd_en && !empty;

  always_ff @(posedge clk_125m) begin
    if (do_wr) mem[wp[AW-1:0]] <= wr_data;
  end

  // Head register takes the incoming word when it becomes the only entry,
  // otherwise the entry behind the one being popped.
  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      wp      <= '0;
      rp      <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wp <= wp + PW'(1);
      if (do_rd) rp <= rp + PW'(1);
      if (do_wr && (empty || (do_rd && cnt == PW'(1))))
        rd_data <= wr_data;
      else if (do_rd)
        rd_data <= mem[rp_nxt];
    end
  end

endmodule

// File: rtl/udp_tx_payload_buf.sv
// Store-and-forward payload buffer feeding the UDP TX engine.
// Optional idle auto-close of an open frame: define UDP_PAYLOAD_TIMEOUT_EN.
module udp_tx_payload_buf
  import udp_tx_payload_buf_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2     = UDP_DEPTH_LOG2,
  parameter int unsigned LEN_DEPTH_LOG2 = UDP_LEN_DEPTH_LOG2,
  parameter int unsigned MAX_LEN        = UDP_MAX_LEN
`ifdef UDP_PAYLOAD_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC    = UDP_TIMEOUT_CYC
`endif
) (
  input  logic        clk_125m,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        wr_last,
  output logic        wr_ready,
  output logic        wr_err,
  output logic        tx_en_pulse,
  output logic [15:0] data_len,
  input  logic        payload_req,
  output logic [7:0]  payload_dat,
  input  logic        tx_done
);

  localparam int unsigned PW = DEPTH_LOG2 + 1;

  logic [7:0]    mem [2**DEPTH_LOG2];
  logic [PW-1:0] wr_ptr, rd_ptr, end_ptr;
  logic [15:0]   frm_cnt, frm_cnt_nxt, sent_cnt;
  logic [15:0]   len_head, len_push_data;
  logic          buf_full, len_full, len_empty;
  logic          accept, close_frm, len_push, len_pop;
  tx_state_e     state;

  assign buf_full    = (wr_ptr ^ rd_ptr) == {1'b1, {DEPTH_LOG2{1'b0}}};
  assign frm_cnt_nxt = frm_cnt + 16'd1;
  assign accept      = wr_en && wr_ready;
  assign close_frm   = accept && (wr_last || frm_cnt_nxt == 16'(MAX_LEN));
  assign len_pop     = (state == IDLE) && !len_empty;
  assign payload_dat = mem[rd_ptr[DEPTH_LOG2-1:0]];

`ifdef UDP_PAYLOAD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] idle_cnt;
  logic          frm_open, to_due, to_fire;

  // to_due holds off further writes if the close had to wait for queue space.
  assign frm_open      = (frm_cnt != '0);
  assign to_due        = frm_open && (idle_cnt == TW'(TIMEOUT_CYC));
  assign to_fire       = frm_open && !accept && !len_full && (idle_cnt >= TW'(TIMEOUT_CYC - 1));
  assign wr_ready      = !buf_full && !len_full && !to_due;
  assign len_push      = close_frm || to_fire;
  assign len_push_data = close_frm ? frm_cnt_nxt : frm_cnt;

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n)
      idle_cnt <= '0;
    else if (accept || to_fire || !frm_open)
      idle_cnt <= '0;
    else if (idle_cnt != TW'(TIMEOUT_CYC))
      idle_cnt <= idle_cnt + TW'(1);
  end
`else
  assign wr_ready      = !buf_full && !len_full;
  assign len_push      = close_frm;
  assign len_push_data = frm_cnt_nxt;
`endif

  always_ff @(posedge clk_125m) begin
    if (accept) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      frm_cnt <= '0;
      wr_err  <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ready;
      if (accept) begin
        wr_ptr  <= wr_ptr + PW'(1);
        frm_cnt <= close_frm ? '0 : frm_cnt_nxt;
      end
`ifdef UDP_PAYLOAD_TIMEOUT_EN
      else if (to_fire)
        frm_cnt <= '0;
`endif
    end
  end

  udp_len_fifo #(
    .DW (16),
    .AW (LEN_DEPTH_LOG2)
  ) u_len_fifo (
    .clk_125m (clk_125m),
    .rst_n    (rst_n),
    .wr_en    (len_push),
    .wr_data  (len_push_data),
    .rd_en    (len_pop),
    .rd_data  (len_head),
    .full     (len_full),
    .empty    (len_empty)
  );

  // end_ptr marks the frame boundary so an early tx_done can skip the tail.
  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_en_pulse <= 1'b0;
      data_len    <= '0;
      rd_ptr      <= '0;
      end_ptr     <= '0;
      sent_cnt    <= '0;
    end else begin
      tx_en_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (!len_empty) begin
            state       <= START;
            tx_en_pulse <= 1'b1;
            data_len    <= len_head;
            end_ptr     <= rd_ptr + PW'(len_head);
            sent_cnt    <= '0;
          end
        end
        START: state <= SEND;
        SEND: begin
          if (tx_done) begin
            state  <= IDLE;
            rd_ptr <= end_ptr;
          end else if (payload_req) begin
            rd_ptr   <= rd_ptr + PW'(1);
            sent_cnt <= sent_cnt + 16'd1;
            if (sent_cnt + 16'd1 == data_len) state <= WAIT_DONE;
          end
        end
        WAIT_DONE: if (tx_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
